fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, default reset vector
// and the fetch FSM state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_VALID = 2'd2,
    FETCH_DROP  = 2'd3
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if;

  logic                       req;
  logic [riscv_pkg::XLEN-1:0] addr;
  logic                       gnt;
  logic                       rvalid;
  logic [riscv_pkg::XLEN-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: requests one word at pc, presents
// it downstream, and restarts cleanly on flush (dropping any stale response).
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_next,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            inst_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  output logic            inst_misaligned,
  fetch_unit_if.master    imem
);

  fetch_state_e    state_r;
  fetch_state_e    state_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_s;
  logic [XLEN-1:0] inst_r;
  logic [XLEN-1:0] inst_s;
  logic            misaligned_r;
  logic            misaligned_s;

  // State, pc, instruction and misalignment registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= FETCH_REQ;
      pc_r         <= RESET_PC;
      inst_r       <= 32'h0000_0000;
      misaligned_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      inst_r       <= inst_s;
      misaligned_r <= misaligned_s;
    end
  end

  // Next-state logic; flush always wins and only redirects pc.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    inst_s       = inst_r;
    misaligned_s = misaligned_r;
    case (state_r)
      FETCH_REQ: begin
        if (is_misaligned(pc_r)) begin
          // No bus request; the fault is presented in place of an instruction.
          if (flush) begin
            pc_s = flush_pc;
          end else begin
            state_s      = FETCH_VALID;
            inst_s       = 32'h0000_0000;
            misaligned_s = 1'b1;
          end
        end else if (flush) begin
          pc_s = flush_pc;
          if (imem.gnt) begin
            state_s = FETCH_DROP;
          end else begin
            state_s = FETCH_REQ;
          end
        end else if (imem.gnt) begin
          state_s = FETCH_WAIT;
        end else begin
          state_s = FETCH_REQ;
        end
      end
      FETCH_WAIT: begin
        if (flush) begin
          pc_s = flush_pc;
          if (imem.rvalid) begin
            state_s = FETCH_REQ;
          end else begin
            state_s = FETCH_DROP;
          end
        end else if (imem.rvalid) begin
          inst_s  = imem.rdata;
          state_s = FETCH_VALID;
        end else begin
          state_s = FETCH_WAIT;
        end
      end
      FETCH_VALID: begin
        if (flush) begin
          pc_s         = flush_pc;
          misaligned_s = 1'b0;
          state_s      = FETCH_REQ;
        end else if (inst_ready) begin
          pc_s         = pc_next;
          misaligned_s = 1'b0;
          state_s      = FETCH_REQ;
        end else begin
          state_s = FETCH_VALID;
        end
      end
      FETCH_DROP: begin
        if (flush) begin
          pc_s = flush_pc;
        end else begin
          pc_s = pc_r;
        end
        if (imem.rvalid) begin
          state_s = FETCH_REQ;
        end else begin
          state_s = FETCH_DROP;
        end
      end
      default: begin
        state_s = FETCH_REQ;
      end
    endcase
  end

  // Bus strobe and valid decode; rst_n gates the request while in reset.
  always_comb begin
    imem.addr  = pc_r;
    imem.req   = 1'b0;
    inst_valid = 1'b0;
    if (rst_n && (state_r == FETCH_REQ) && !is_misaligned(pc_r)) begin
      imem.req = 1'b1;
    end else begin
      imem.req = 1'b0;
    end
    if ((state_r == FETCH_VALID) && !flush) begin
      inst_valid = 1'b1;
    end else begin
      inst_valid = 1'b0;
    end
  end

  assign pc              = pc_r;
  assign inst            = inst_r;
  assign inst_misaligned = misaligned_r;

endmodule
